// File: rtl/red_operand_packer_if.sv
// ---------------------------------------------------------------------------
// red_operand_packer_if
//   Handshake bundle between a byte source, the RED operand packer and the
//   reduction execute stage.
//
//   Signals:
//     flush      source -> packer  synchronous discard of partial/held group
//     in_valid   source -> packer  byte source has a byte
//     in_byte    source -> packer  8-bit byte payload
//     in_ready   packer -> source  packer accepts the byte this cycle
//     out_valid  packer -> sink    rs/rt hold a complete group
//     out_ready  sink   -> packer  consumer takes the group this cycle
//     rs, rt     packer -> sink    16-bit packed operands
//     timeout    packer -> sink    one-cycle pulse, partial group timed out
//     red_sum    packer -> sink    RED-equivalent sum of the held group
//
//   Modports:
//     master  the stream driver / consumer side (testbench, source logic)
//     slave   the packer itself
// ---------------------------------------------------------------------------
interface red_operand_packer_if;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        timeout;
  logic [15:0] red_sum;

  modport master (
    output flush, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, rs, rt, timeout, red_sum
  );

  modport slave (
    input  flush, in_valid, in_byte, out_ready,
    output in_ready, out_valid, rs, rt, timeout, red_sum
  );
endinterface

// File: rtl/red_operand_packer.sv
// ---------------------------------------------------------------------------
// red_operand_packer
//   Byte-stream front end for the RED reduction datapath. Collects four
//   accepted bytes into one group, presents the group as the two 16-bit
//   operands rs/rt on a valid/ready output, and can overlap delivery of a
//   full group with acceptance of the first byte of the next one, so the
//   sustained rate is one byte per cycle.
//
//   Parameters:
//     LOW_FIRST     1: byte 0 lands in rs[7:0]; 0: byte 0 lands in rs[15:8]
//     FILL_TIMEOUT  idle cycles a partial group may wait before it is
//                   dropped; 0 disables the timeout
//
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    red_operand_packer_if.slave (flush, byte input handshake,
//            operand output handshake, timeout pulse, red_sum)
//
//   Build option:
//     RED_PACK_SUM_EN  when defined, red_sum is a registered RED-equivalent
//                      sum of the group; otherwise red_sum is tied to zero
//                      and no adder is built.
// ---------------------------------------------------------------------------
module red_operand_packer #(
  parameter int LOW_FIRST    = 1,
  parameter int FILL_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  red_operand_packer_if.slave  bus
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // The idle counter only has to count 0..FILL_TIMEOUT-1.
  localparam int IDLE_W = (FILL_TIMEOUT > 2) ? $clog2(FILL_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    (FILL_TIMEOUT > 0) ? IDLE_W'(FILL_TIMEOUT - 1) : '0;

  // The group is kept as one 32-bit word {rt, rs}; byte position 0 is
  // rs[7:0]. High-first order just swaps the two bytes inside each operand,
  // which is a flip of bit 0 of the slot number.
  localparam logic [1:0] SLOT_XOR = (LOW_FIRST != 0) ? 2'b00 : 2'b01;

  state_t            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       group_q, group_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;

  logic              inReady;
  logic              accept;
  logic              deliver;

  // Flush masks both handshakes so a byte offered during a flush is never
  // reported as taken.
  assign inReady = !bus.flush && ((state_q == FILL) || bus.out_ready);
  assign accept  = bus.in_valid && inReady;
  assign deliver = (state_q == FULL) && bus.out_ready && !bus.flush;

  // Next-state logic: flush wins over everything, then the FILL/FULL
  // behaviour. Starting a new group always clears the unwritten slots so a
  // partial group reads zero in the slots not yet filled.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    group_d   = group_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;

    if (bus.flush) begin
      state_d = FILL;
      count_d = 2'd0;
      group_d = '0;
      idle_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            group_d[{count_q ^ SLOT_XOR, 3'b000} +: 8] = bus.in_byte;
            idle_d = '0;
            if (count_q == 2'd3) begin
              state_d = FULL;
              count_d = 2'd0;
            end else begin
              count_d = count_q + 2'd1;
            end
          end else if ((FILL_TIMEOUT > 0) && (count_q != 2'd0)) begin
            if (idle_q == IDLE_LAST) begin
              count_d   = 2'd0;
              group_d   = '0;
              idle_d    = '0;
              timeout_d = 1'b1;
            end else begin
              idle_d = idle_q + IDLE_W'(1);
            end
          end
        end

        FULL: begin
          idle_d = '0;
          if (deliver) begin
            state_d = FILL;
            count_d = 2'd0;
            group_d = '0;
            if (accept) begin
              group_d[{SLOT_XOR, 3'b000} +: 8] = bus.in_byte;
              count_d = 2'd1;
            end
          end
        end

        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State and output registers; reset drops any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      count_q   <= 2'd0;
      group_q   <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      group_q   <= group_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == FULL);
  assign bus.rs        = group_q[15:0];
  assign bus.rt        = group_q[31:16];
  assign bus.timeout   = timeout_q;

`ifdef RED_PACK_SUM_EN
  logic [15:0] redSum_q, redSum_d;
  logic [8:0]  sumRs, sumRt, sumAll;

  // RED-equivalent sum of the next group contents, so it lands in the same
  // cycle as rs/rt. The 9-bit total is sign-extended from bit 8 exactly as
  // the RED unit does.
  always_comb begin
    sumRs    = {1'b0, group_d[15:8]}  + {1'b0, group_d[7:0]};
    sumRt    = {1'b0, group_d[31:24]} + {1'b0, group_d[23:16]};
    sumAll   = sumRs + sumRt;
    redSum_d = {{7{sumAll[8]}}, sumAll};
  end

  // Sum register, cleared on reset along with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redSum_q <= 16'h0000;
    end else begin
      redSum_q <= redSum_d;
    end
  end

  assign bus.red_sum = redSum_q;
`else
  assign bus.red_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_red_operand_packer.sv
// ---------------------------------------------------------------------------
// tb_red_operand_packer
//   Directed bench for red_operand_packer. Main instance: LOW_FIRST=1,
//   FILL_TIMEOUT=5. A second instance with LOW_FIRST=0, FILL_TIMEOUT=0 sees
//   the same input stream and its complete groups are compared against the
//   byte-swapped expectation.
// ---------------------------------------------------------------------------
module tb_red_operand_packer;

  logic clk;
  logic rst_n;

  red_operand_packer_if bus0();
  red_operand_packer_if bus1();

  red_operand_packer #(.LOW_FIRST(1), .FILL_TIMEOUT(5)) dutLow (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  red_operand_packer #(.LOW_FIRST(0), .FILL_TIMEOUT(0)) dutHigh (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Both instances see the same source/sink stimulus.
  assign bus1.flush     = bus0.flush;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_byte   = bus0.in_byte;
  assign bus1.out_ready = bus0.out_ready;

  // 100 MHz style clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fl;
    logic        iv;
    logic [7:0]  b;
    logic        ordy;
    logic        chkRdy;
    logic        expRdy;
    logic        expValid;
    logic        chkData;
    logic [15:0] expRs;
    logic [15:0] expRt;
    logic        expTmo;
  } vec_t;

  int checkCnt = 0;
  int passCnt  = 0;

  // Compare one value and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the input side for the coming clock edge.
  task automatic applyStimulus(input logic fl, input logic iv,
                               input logic [7:0] b, input logic ordy);
    bus0.flush     = fl;
    bus0.in_valid  = iv;
    bus0.in_byte   = b;
    bus0.out_ready = ordy;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RED sum reference: 9-bit pair sums, 9-bit total, sign-extend bit 8.
  function automatic logic [15:0] redModel(input logic [15:0] a,
                                           input logic [15:0] b);
    logic [8:0] s1, s2, t;
    s1 = {1'b0, a[15:8]} + {1'b0, a[7:0]};
    s2 = {1'b0, b[15:8]} + {1'b0, b[7:0]};
    t  = s1 + s2;
`ifdef RED_PACK_SUM_EN
    return {{7{t[8]}}, t};
`else
    return (t == 9'h000) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] swapBytes(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  vec_t       vecs[$];
  logic [7:0] grp[4];

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;

    // Table: fl iv byte ordy | chkRdy expRdy | expValid chkData rs rt tmo
    // group 01..04, then delivery
    vecs.push_back('{0,1,8'h01,0, 1,1, 0,1,16'h0001,16'h0000,0});
    vecs.push_back('{0,1,8'h02,0, 1,1, 0,1,16'h0201,16'h0000,0});
    vecs.push_back('{0,1,8'h03,0, 1,1, 0,1,16'h0201,16'h0003,0});
    vecs.push_back('{0,1,8'h04,0, 1,1, 1,1,16'h0201,16'h0403,0});
    vecs.push_back('{0,0,8'h00,1, 1,1, 0,0,16'h0000,16'h0000,0});
    // group 80,80,00,00 held under back-pressure for 3 cycles
    vecs.push_back('{0,1,8'h80,0, 1,1, 0,0,16'h0000,16'h0000,0});
    vecs.push_back('{0,1,8'h80,0, 1,1, 0,0,16'h0000,16'h0000,0});
    vecs.push_back('{0,1,8'h00,0, 1,1, 0,0,16'h0000,16'h0000,0});
    vecs.push_back('{0,1,8'h00,0, 1,1, 1,1,16'h8080,16'h0000,0});
    vecs.push_back('{0,1,8'h55,0, 1,0, 1,1,16'h8080,16'h0000,0});
    vecs.push_back('{0,1,8'h55,0, 1,0, 1,1,16'h8080,16'h0000,0});
    vecs.push_back('{0,1,8'h55,0, 1,0, 1,1,16'h8080,16'h0000,0});
    // continuous 8-byte stream with out_ready=1, overlapping deliveries
    vecs.push_back('{0,1,8'h11,1, 1,1, 0,1,16'h0011,16'h0000,0});
    vecs.push_back('{0,1,8'h22,1, 1,1, 0,1,16'h2211,16'h0000,0});
    vecs.push_back('{0,1,8'h33,1, 1,1, 0,1,16'h2211,16'h0033,0});
    vecs.push_back('{0,1,8'h44,1, 1,1, 1,1,16'h2211,16'h4433,0});
    vecs.push_back('{0,1,8'h55,1, 1,1, 0,1,16'h0055,16'h0000,0});
    vecs.push_back('{0,1,8'h66,1, 1,1, 0,1,16'h6655,16'h0000,0});
    vecs.push_back('{0,1,8'h77,1, 1,1, 0,1,16'h6655,16'h0077,0});
    vecs.push_back('{0,1,8'h88,1, 1,1, 1,1,16'h6655,16'h8877,0});
    // flush in FULL with out_ready=1 and a byte offered
    vecs.push_back('{1,1,8'h99,1, 0,0, 0,1,16'h0000,16'h0000,0});
    // the next group must not contain the flushed byte
    vecs.push_back('{0,1,8'hA1,0, 1,1, 0,1,16'h00A1,16'h0000,0});
    vecs.push_back('{0,1,8'hA2,0, 1,1, 0,1,16'hA2A1,16'h0000,0});
    vecs.push_back('{0,1,8'hA3,0, 1,1, 0,1,16'hA2A1,16'h00A3,0});
    vecs.push_back('{0,1,8'hA4,0, 1,1, 1,1,16'hA2A1,16'hA4A3,0});
    vecs.push_back('{0,0,8'h00,1, 1,1, 0,0,16'h0000,16'h0000,0});

    // Reset state, then release between edges.
    #12;
    checkOutput("reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
    checkOutput("reset rs", {16'd0, bus0.rs}, 32'd0);
    checkOutput("reset rt", {16'd0, bus0.rt}, 32'd0);
    checkOutput("reset timeout", {31'd0, bus0.timeout}, 32'd0);
    checkOutput("reset red_sum", {16'd0, bus0.red_sum}, 32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", {31'd0, bus0.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table-driven section.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fl, vecs[i].iv, vecs[i].b, vecs[i].ordy);
      #1;
      if (vecs[i].chkRdy)
        checkOutput($sformatf("v%0d in_ready", i), {31'd0, bus0.in_ready},
                    {31'd0, vecs[i].expRdy});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d out_valid", i), {31'd0, bus0.out_valid},
                  {31'd0, vecs[i].expValid});
      checkOutput($sformatf("v%0d timeout", i), {31'd0, bus0.timeout},
                  {31'd0, vecs[i].expTmo});
      if (vecs[i].chkData) begin
        checkOutput($sformatf("v%0d rs", i), {16'd0, bus0.rs},
                    {16'd0, vecs[i].expRs});
        checkOutput($sformatf("v%0d rt", i), {16'd0, bus0.rt},
                    {16'd0, vecs[i].expRt});
      end
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d red_sum", i), {16'd0, bus0.red_sum},
                    {16'd0, redModel(vecs[i].expRs, vecs[i].expRt)});
        checkOutput($sformatf("v%0d hi-first valid", i),
                    {31'd0, bus1.out_valid}, 32'd1);
        checkOutput($sformatf("v%0d hi-first rs", i), {16'd0, bus1.rs},
                    {16'd0, swapBytes(vecs[i].expRs)});
        checkOutput($sformatf("v%0d hi-first rt", i), {16'd0, bus1.rt},
                    {16'd0, swapBytes(vecs[i].expRt)});
      end
    end

    // Timeout: 2 bytes, then 5 idle cycles -> one pulse, partial dropped.
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
    tick();
    checkOutput("partial rs before idle", {16'd0, bus0.rs}, 32'h0000A55A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("idle%0d timeout", k), {31'd0, bus0.timeout},
                  (k == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("timeout rs cleared", {16'd0, bus0.rs}, 32'd0);
    checkOutput("timeout rt cleared", {16'd0, bus0.rt}, 32'd0);
    tick();
    checkOutput("timeout pulse width", {31'd0, bus0.timeout}, 32'd0);
    grp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, grp[k], 1'b0);
      tick();
    end
    checkOutput("post-timeout out_valid", {31'd0, bus0.out_valid}, 32'd1);
    checkOutput("post-timeout rs", {16'd0, bus0.rs}, 32'h0000C2C1);
    checkOutput("post-timeout rt", {16'd0, bus0.rt}, 32'h0000C4C3);
    checkOutput("post-timeout red_sum", {16'd0, bus0.red_sum},
                {16'd0, redModel(16'hC2C1, 16'hC4C3)});
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("post-timeout delivered", {31'd0, bus0.out_valid}, 32'd0);

    // Asynchronous reset mid-group (count=2).
    applyStimulus(1'b0, 1'b1, 8'hD1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hD2, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pre-reset partial rs", {16'd0, bus0.rs}, 32'h0000D2D1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset rs", {16'd0, bus0.rs}, 32'd0);
    checkOutput("async reset rt", {16'd0, bus0.rt}, 32'd0);
    checkOutput("async reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
    checkOutput("async reset red_sum", {16'd0, bus0.red_sum}, 32'd0);
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("after async reset in_ready", {31'd0, bus0.in_ready}, 32'd1);
    grp = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, grp[k], 1'b0);
      tick();
    end
    checkOutput("post-reset group out_valid", {31'd0, bus0.out_valid}, 32'd1);
    checkOutput("post-reset group rs", {16'd0, bus0.rs}, 32'h0000E2E1);
    checkOutput("post-reset group rt", {16'd0, bus0.rt}, 32'h0000E4E3);
    checkOutput("post-reset group red_sum", {16'd0, bus0.red_sum},
                {16'd0, redModel(16'hE2E1, 16'hE4E3)});
    checkOutput("post-reset hi-first rs", {16'd0, bus1.rs}, 32'h0000E1E2);
    checkOutput("post-reset hi-first rt", {16'd0, bus1.rt}, 32'h0000E3E4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
